// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, sizes and coefficient FSM states for the FIR host path
package fir_pkg;
    localparam int FP16_W    = 16;
    localparam int FP16I_W   = 17;
    localparam int FP29I_W   = 29;
    localparam int NCOEF     = 64;
    localparam int FRAME_LEN = 256;
    localparam int CADDR_W   = 6;

    typedef enum logic [1:0] {
        C_IDLE,
        C_STROBE,
        C_HOLD,
        C_DONE
    } coef_state_t;
endpackage

// File: rtl/fir_smp_fifo.sv
// rtl/fir_smp_fifo.sv - small synchronous sample FIFO with occupancy level
module fir_smp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/fir_stream_tx.sv
// rtl/fir_stream_tx.sv - loads FIR coefficients in frame 0, then streams one sample per frame
module fir_stream_tx #(
    parameter int FRAME_LEN  = fir_pkg::FRAME_LEN,
    parameter int NCOEF      = fir_pkg::NCOEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                coef_valid,
    input  logic [fir_pkg::FP16I_W-1:0]         coef_data,
    output logic                                coef_ready,
    input  logic                                smp_valid,
    input  logic [fir_pkg::FP16_W-1:0]          smp_data,
    output logic                                smp_ready,
    output logic [fir_pkg::FP16_W-1:0]          din,
    output logic                                valid_in,
    output logic [fir_pkg::FP16I_W-1:0]         cin,
    output logic [fir_pkg::CADDR_W-1:0]         caddr,
    output logic                                cload,
    output logic                                coef_done,
    output logic                                coef_err,
    output logic                                underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);
    import fir_pkg::*;

    localparam int FC_W = $clog2(FRAME_LEN);

    logic [FC_W-1:0]   frame_cnt;
    logic              frame_tick;
    coef_state_t       state;
    coef_state_t       state_next;
    logic              coef_hs;
    logic              last_addr;
    logic [FP16_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    assign frame_tick = (frame_cnt == FC_W'(FRAME_LEN - 1));
    assign last_addr  = (caddr == CADDR_W'(NCOEF - 1));
    // Ready is withheld on the tick so a coefficient is never taken and then dropped
    // by the window closing, and withheld in reset so the upstream sees a clean 0.
    assign coef_ready = (state == C_IDLE) && !frame_tick && !rst;
    assign coef_hs    = coef_valid && coef_ready;
    assign smp_ready  = !fifo_full;

    // Free-running frame counter aligned to the FIR sequencer period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             frame_cnt <= '0;
        else if (frame_tick) frame_cnt <= '0;
        else                 frame_cnt <= frame_cnt + 1'b1;
    end

    // Coefficient FSM next state; the first tick closes the load window from any state.
    always_comb begin
        state_next = state;
        case (state)
            C_IDLE:   if (coef_hs) state_next = C_STROBE;
            C_STROBE: state_next = C_HOLD;
            C_HOLD:   state_next = last_addr ? C_DONE : C_IDLE;
            C_DONE:   state_next = C_DONE;
            default:  state_next = C_IDLE;
        endcase
        if (frame_tick) state_next = C_DONE;
    end

    // Coefficient registers; cload is registered so the CMEM clock is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= C_IDLE;
            cin       <= '0;
            caddr     <= '0;
            cload     <= 1'b0;
            coef_done <= 1'b0;
            coef_err  <= 1'b0;
        end else begin
            state <= state_next;
            cload <= (state_next == C_STROBE);
            if (coef_hs) cin <= coef_data;
            // The last address is kept so caddr reads NCOEF-1 once loading is complete.
            if (state == C_HOLD && !last_addr) caddr <= caddr + 1'b1;
            if (state == C_HOLD && last_addr && !frame_tick) coef_done <= 1'b1;
            if (frame_tick && state != C_DONE) coef_err <= 1'b1;
        end
    end

    // Sample launch: every tick presents a new din (zero on underrun) with a one-cycle valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din      <= '0;
            valid_in <= 1'b0;
            underrun <= 1'b0;
        end else begin
            valid_in <= frame_tick;
            if (frame_tick) begin
                if (fifo_empty) begin
                    din      <= '0;
                    underrun <= 1'b1;
                end else begin
                    din <= fifo_rdata;
                end
            end
        end
    end

    fir_smp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FP16_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (smp_valid && smp_ready),
        .pop   (frame_tick),
        .wdata (smp_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );
endmodule
